iiitb_dmem_arb: RTL and testbench

//  Arbiter/controller for the single-port 64x32 data memory of the iiitb_rv32i core.
//  - Shares DMEM between two requesters: the pipeline MEM stage (core port, c_*) and a debug/program-loader port (d_*).
//  - Raises a stall to the pipeline whenever a core access is not granted.
//  - Returns read data with a fixed 1-cycle latency.

---
 rtl/iiitb_rv32i_pkg.sv | 20 ++
 rtl/iiitb_rr_pick2.sv | 21 ++
 rtl/iiitb_dmem_arb.sv | 171 +++++++++++++++++
 tb/tb_iiitb_dmem_arb.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iiitb_rv32i_pkg.sv
// Shared types and constants for the iiitb_rv32i data-memory arbiter.
package iiitb_rv32i_pkg;

    localparam int unsigned DMEM_AW = 6;
    localparam int unsigned DMEM_DW = 32;
    localparam int unsigned LOCK_CW = 8;
    localparam int unsigned SCNT_W  = 16;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        DLOCK = 2'd1,
        FORCE = 2'd2
    } arb_state_e;

    typedef enum logic {
        CORE = 1'b0,
        DBG  = 1'b1
    } owner_e;

endpackage

// File: rtl/iiitb_rr_pick2.sv
// Two-way round-robin picker: bit 0 = core, bit 1 = debug.
// On a tie the requester that was not the last owner wins.
module iiitb_rr_pick2
    import iiitb_rv32i_pkg::*;
(
    input  logic [1:0] req_i,
    input  owner_e     last_owner_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_owner_i == DBG) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/iiitb_dmem_arb.sv
// Single-port DMEM arbiter between the core MEM stage and the debug/loader port.
// Defining DMEM_ARB_PERF_EN adds a saturating stall-cycle counter output.
module iiitb_dmem_arb
    import iiitb_rv32i_pkg::*;
#(
    parameter int unsigned AW       = DMEM_AW,
    parameter int unsigned DW       = DMEM_DW,
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              RN,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [AW-1:0]     c_addr,
    input  logic [DW-1:0]     c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DW-1:0]     c_rdata,
    output logic              stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_lock,
    input  logic [AW-1:0]     d_addr,
    input  logic [DW-1:0]     d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DW-1:0]     d_rdata,
    output logic              m_en,
    output logic              m_we,
    output logic [AW-1:0]     m_addr,
    output logic [DW-1:0]     m_wdata,
    input  logic [DW-1:0]     m_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [SCNT_W-1:0] stall_cnt
`endif
);

    arb_state_e         state_q, state_d;
    owner_e             last_q, last_d;
    logic [LOCK_CW-1:0] lock_cnt_q, lock_cnt_d;
    logic [LOCK_CW-1:0] lock_inc;
    logic [1:0]         rr_gnt;
    logic               c_rvalid_q, d_rvalid_q;
    logic [DW-1:0]      c_rdata_q, d_rdata_q;

    iiitb_rr_pick2 u_pick (
        .req_i        ({d_req, c_req}),
        .last_owner_i (last_q),
        .gnt_o        (rr_gnt)
    );

    always_ff @(posedge clk) begin
        if (RN) begin
            state_q    <= ARB;
            last_q     <= DBG;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    assign lock_inc = (&lock_cnt_q) ? lock_cnt_q : lock_cnt_q + LOCK_CW'(1);

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            ARB: begin
                if (c_gnt) last_d = CORE;
                if (d_gnt) begin
                    last_d = DBG;
                    if (d_lock) begin
                        state_d    = DLOCK;
                        lock_cnt_d = '0;
                    end
                end
            end
            DLOCK: begin
                if (d_gnt) last_d = DBG;
                if (c_req) lock_cnt_d = lock_inc;
                // The core is forced in once LOCK_MAX locked debug cycles have passed it by
                if (!d_req || !d_lock) begin
                    state_d    = ARB;
                    lock_cnt_d = '0;
                end else if (c_req && (lock_inc == LOCK_CW'(LOCK_MAX))) begin
                    state_d    = FORCE;
                    lock_cnt_d = '0;
                end
            end
            FORCE: begin
                state_d = ARB;
                last_d  = CORE;
            end
            default: state_d = ARB;
        endcase
    end

    // Grants are withheld in the reset cycle so nothing reaches the memory
    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!RN) begin
            case (state_q)
                ARB: begin
                    c_gnt = rr_gnt[0];
                    d_gnt = rr_gnt[1];
                end
                DLOCK:   d_gnt = d_req;
                FORCE:   c_gnt = c_req;
                default: ;
            endcase
        end
    end

    assign stall = c_req & ~c_gnt;
    assign m_en  = c_gnt | d_gnt;

    always_comb begin
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (c_gnt) begin
            m_we    = c_we;
            m_addr  = c_addr;
            m_wdata = c_wdata;
        end else if (d_gnt) begin
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end
    end

    // Read return path: data is live from the SRAM in the valid cycle, held afterwards
    always_ff @(posedge clk) begin
        if (RN) begin
            c_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            c_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            c_rvalid_q <= c_gnt & ~c_we;
            d_rvalid_q <= d_gnt & ~d_we;
            if (c_rvalid_q) c_rdata_q <= m_rdata;
            if (d_rvalid_q) d_rdata_q <= m_rdata;
        end
    end

    assign c_rvalid = c_rvalid_q & ~RN;
    assign d_rvalid = d_rvalid_q & ~RN;
    assign c_rdata  = c_rvalid_q ? m_rdata : c_rdata_q;
    assign d_rdata  = d_rvalid_q ? m_rdata : d_rdata_q;

`ifdef DMEM_ARB_PERF_EN
    logic [SCNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (RN) begin
            stall_cnt_q <= '0;
        end else if (stall && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + SCNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_iiitb_dmem_arb.sv
// Bench for iiitb_dmem_arb: directed vector table, hand sequences and random traffic
// checked against a transaction-level arbitration and memory model.
module tb_iiitb_dmem_arb;
    import iiitb_rv32i_pkg::*;

    localparam int unsigned AW       = 6;
    localparam int unsigned DW       = 32;
    localparam int unsigned LOCK_MAX = 8;

    logic          clk = 1'b0;
    logic          RN;
    logic          c_req, c_we, c_gnt, c_rvalid, stall;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata, c_rdata;
    logic          d_req, d_we, d_lock, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          m_en, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [15:0]   stall_cnt;
`endif

    always #5 clk = ~clk;

    iiitb_dmem_arb #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .RN(RN),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .stall(stall),
        .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
`ifdef DMEM_ARB_PERF_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    // Synchronous single-port SRAM driven by the DUT
    logic [DW-1:0] sram [64];
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) sram[m_addr] <= m_wdata;
            else      m_rdata      <= sram[m_addr];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: memory image, lock budget and ownership history
    logic [DW-1:0] ref_mem [64];
    bit            locked, forced, last_dbg;
    int            budget;
    bit            exp_crv, exp_drv;
    logic [DW-1:0] exp_crd, exp_drd;
    int            exp_scnt;
    bit            eg_c_s, eg_d_s, smp_cg, smp_dg;

    typedef struct {
        bit            cr, cw;
        logic [AW-1:0] ca;
        logic [DW-1:0] cd;
        bit            dr, dw, dl;
        logic [AW-1:0] da;
        logic [DW-1:0] dd;
        bit            ecg, edg, est, ecrv;
        logic [DW-1:0] ecrd;
    } vec_t;

    vec_t tab [12];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
        end
    endfunction

    function automatic logic [DW-1:0] sweep_val(input int i);
        return (i == 5) ? 32'h0000_00A5 : (32'h5A00_0000 | 32'(i));
    endfunction

    task automatic model_reset();
        locked   = 1'b0;
        forced   = 1'b0;
        last_dbg = 1'b1;
        exp_crv  = 1'b0;
        exp_drv  = 1'b0;
        exp_crd  = '0;
        exp_drd  = '0;
        exp_scnt = 0;
    endtask

    task automatic drive(input bit cr, input bit cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                         input bit dr, input bit dw, input bit dl, input logic [AW-1:0] da,
                         input logic [DW-1:0] dd);
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        d_req = dr; d_we = dw; d_lock = dl; d_addr = da; d_wdata = dd;
    endtask

    // One clock: called just after the falling edge with inputs already driven
    task automatic cycle();
        bit eg_c, eg_d;
        #1;
        eg_c = 1'b0;
        eg_d = 1'b0;
        if (!RN) begin
            if (forced)                  eg_c = c_req;
            else if (locked)             eg_d = d_req;
            else if (c_req && d_req) begin
                eg_c = last_dbg;
                eg_d = !last_dbg;
            end else begin
                eg_c = c_req;
                eg_d = d_req;
            end
        end
        chk("c_gnt", 32'(c_gnt), 32'(eg_c));
        chk("d_gnt", 32'(d_gnt), 32'(eg_d));
        chk("stall", 32'(stall), 32'(c_req & ~eg_c));
        chk("m_en",  32'(m_en),  32'(eg_c | eg_d));
        if (eg_c) begin
            chk("m_we_c",   32'(m_we),   32'(c_we));
            chk("m_addr_c", 32'(m_addr), 32'(c_addr));
            if (c_we) chk("m_wdata_c", m_wdata, c_wdata);
        end else if (eg_d) begin
            chk("m_we_d",   32'(m_we),   32'(d_we));
            chk("m_addr_d", 32'(m_addr), 32'(d_addr));
            if (d_we) chk("m_wdata_d", m_wdata, d_wdata);
        end
        chk("c_rvalid", 32'(c_rvalid), 32'(exp_crv & !RN));
        chk("d_rvalid", 32'(d_rvalid), 32'(exp_drv & !RN));
        if (!RN) begin
            chk("c_rdata", c_rdata, exp_crd);
            chk("d_rdata", d_rdata, exp_drd);
`ifdef DMEM_ARB_PERF_EN
            chk("stall_cnt", 32'(stall_cnt), 32'(exp_scnt));
`endif
        end
        smp_cg = c_gnt;
        smp_dg = d_gnt;
        eg_c_s = eg_c;
        eg_d_s = eg_d;
        @(posedge clk);
        if (RN) begin
            model_reset();
        end else begin
            if (c_req && !eg_c && exp_scnt < 65535) exp_scnt++;
            exp_crv = eg_c && !c_we;
            exp_drv = eg_d && !d_we;
            if (exp_crv) exp_crd = ref_mem[c_addr];
            if (exp_drv) exp_drd = ref_mem[d_addr];
            if (eg_c && c_we) ref_mem[c_addr] = c_wdata;
            if (eg_d && d_we) ref_mem[d_addr] = d_wdata;
            if (forced) begin
                forced   = 1'b0;
                last_dbg = 1'b0;
            end else if (locked) begin
                if (eg_d) last_dbg = 1'b1;
                if (!d_req || !d_lock) begin
                    locked = 1'b0;
                end else if (c_req) begin
                    budget--;
                    if (budget == 0) begin
                        locked = 1'b0;
                        forced = 1'b1;
                    end
                end
            end else begin
                if (eg_c) last_dbg = 1'b0;
                if (eg_d) begin
                    last_dbg = 1'b1;
                    if (d_lock) begin
                        locked = 1'b1;
                        budget = LOCK_MAX;
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        bit            cp, cw, dp, dw, dl;
        logic [AW-1:0] ca, da;
        logic [DW-1:0] cd, dd;
        int            n_d, got_c;

        RN = 1'b1;
        drive(0, 0, '0, '0, 0, 0, 0, '0, '0);
        model_reset();
        @(negedge clk);
        cycle();
        drive(1, 0, 6'd1, '0, 1, 1, 1, 6'd2, 32'h1);
        cycle();
        RN = 1'b0;
        drive(0, 0, '0, '0, 0, 0, 0, '0, '0);
        #1;
        chk("rst_c_rvalid", 32'(c_rvalid), 32'd0);
        chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("rst_idle_m_en", 32'(m_en), 32'd0);
        chk("rst_idle_gnt", 32'({c_gnt, d_gnt}), 32'd0);
        @(negedge clk);

        // Preload all words through a locked debug burst
        for (int i = 0; i < 64; i++) begin
            drive(0, 0, '0, '0, 1, 1, (i != 63), AW'(i), sweep_val(i));
            cycle();
        end

        tab[0]  = '{1, 0, 6'd5,  32'h0,  0, 0, 0, 6'd0,  32'h0,    1, 0, 0, 0, 32'h0};
        tab[1]  = '{0, 0, 6'd0,  32'h0,  0, 0, 0, 6'd0,  32'h0,    0, 0, 0, 1, 32'hA5};
        tab[2]  = '{0, 0, 6'd0,  32'h0,  1, 1, 0, 6'd3,  32'h1234, 0, 1, 0, 0, 32'h0};
        tab[3]  = '{1, 0, 6'd3,  32'h0,  0, 0, 0, 6'd0,  32'h0,    1, 0, 0, 0, 32'h0};
        tab[4]  = '{0, 0, 6'd0,  32'h0,  0, 0, 0, 6'd0,  32'h0,    0, 0, 0, 1, 32'h1234};
        tab[5]  = '{0, 0, 6'd0,  32'h0,  1, 0, 0, 6'd10, 32'h0,    0, 1, 0, 0, 32'h0};
        tab[6]  = '{0, 0, 6'd0,  32'h0,  0, 0, 0, 6'd0,  32'h0,    0, 0, 0, 0, 32'h0};
        tab[7]  = '{1, 1, 6'd20, 32'hC0, 1, 1, 0, 6'd30, 32'hD0,   1, 0, 0, 0, 32'h0};
        tab[8]  = '{1, 1, 6'd21, 32'hC1, 1, 1, 0, 6'd30, 32'hD0,   0, 1, 1, 0, 32'h0};
        tab[9]  = '{1, 1, 6'd21, 32'hC1, 1, 1, 0, 6'd31, 32'hD1,   1, 0, 0, 0, 32'h0};
        tab[10] = '{1, 1, 6'd22, 32'hC2, 1, 1, 0, 6'd31, 32'hD1,   0, 1, 1, 0, 32'h0};
        tab[11] = '{0, 0, 6'd0,  32'h0,  0, 0, 0, 6'd0,  32'h0,    0, 0, 0, 0, 32'h0};

        for (int i = 0; i < 12; i++) begin
            drive(tab[i].cr, tab[i].cw, tab[i].ca, tab[i].cd,
                  tab[i].dr, tab[i].dw, tab[i].dl, tab[i].da, tab[i].dd);
            #1;
            chk($sformatf("tab%0d_c_gnt", i), 32'(c_gnt), 32'(tab[i].ecg));
            chk($sformatf("tab%0d_d_gnt", i), 32'(d_gnt), 32'(tab[i].edg));
            chk($sformatf("tab%0d_stall", i), 32'(stall), 32'(tab[i].est));
            chk($sformatf("tab%0d_c_rvalid", i), 32'(c_rvalid), 32'(tab[i].ecrv));
            if (tab[i].ecrv) chk($sformatf("tab%0d_c_rdata", i), c_rdata, tab[i].ecrd);
            cycle();
        end

        // Locked debug burst starves the core for exactly LOCK_MAX grants
        drive(0, 0, '0, '0, 1, 1, 1, 6'd40, 32'hB000);
        cycle();
        n_d   = 0;
        got_c = 0;
        for (int k = 0; k < 30 && got_c == 0; k++) begin
            drive(1, 0, 6'd7, '0, 1, 1, 1, AW'(41 + k % 8), 32'hB100 + 32'(k));
            cycle();
            if (smp_cg) got_c = 1;
            else if (smp_dg) n_d++;
        end
        chk("lock_dbg_grants", 32'(n_d), 32'(LOCK_MAX));
        chk("force_core_grant", 32'(got_c), 32'd1);
        drive(1, 0, 6'd8, '0, 1, 1, 0, 6'd49, 32'hB1FF);
        #1;
        chk("after_force_rr_d", 32'(d_gnt), 32'd1);
        cycle();
        drive(1, 0, 6'd8, '0, 0, 0, 0, '0, '0);
        cycle();

        // Reset while locked with a debug read still in flight
        drive(0, 0, '0, '0, 1, 1, 1, 6'd50, 32'hCAFE);
        cycle();
        drive(0, 0, '0, '0, 1, 0, 1, 6'd11, '0);
        cycle();
        RN = 1'b1;
        drive(1, 0, 6'd13, '0, 1, 1, 1, 6'd12, 32'hDEAD);
        #1;
        chk("rst_mid_m_en", 32'(m_en), 32'd0);
        chk("rst_mid_d_rvalid", 32'(d_rvalid), 32'd0);
        cycle();
        RN = 1'b0;
        drive(1, 0, 6'd13, '0, 1, 0, 0, 6'd14, '0);
        #1;
        chk("rst_arb_c_gnt", 32'(c_gnt), 32'd1);
        chk("rst_arb_d_rvalid", 32'(d_rvalid), 32'd0);
        cycle();
        drive(0, 0, '0, '0, 1, 0, 0, 6'd14, '0);
        cycle();
        drive(1, 0, 6'd12, '0, 0, 0, 0, '0, '0);
        cycle();
        drive(0, 0, '0, '0, 0, 0, 0, '0, '0);
        #1;
        chk("rst_write_dropped", c_rdata, sweep_val(12));
        cycle();

        // Random traffic, requests held until granted, occasional resets
        cp = 0; dp = 0; cw = 0; dw = 0; dl = 0;
        ca = '0; da = '0; cd = '0; dd = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!cp && $urandom_range(0, 1) == 1) begin
                cp = 1; cw = 1'($urandom_range(0, 1)); ca = AW'($urandom); cd = $urandom;
            end
            if (!dp && $urandom_range(0, 2) != 0) begin
                dp = 1; dw = 1'($urandom_range(0, 1)); da = AW'($urandom); dd = $urandom;
                dl = ($urandom_range(0, 3) != 0);
            end
            RN = ($urandom_range(0, 255) == 0);
            drive(cp, cw, ca, cd, dp, dw, dl, da, dd);
            cycle();
            if (eg_c_s) cp = 0;
            if (eg_d_s) dp = 0;
        end
        RN = 1'b0;

`ifdef DMEM_ARB_PERF_EN
        // Drive the stall counter into saturation
        for (int k = 0; k < 90000 && exp_scnt < 65535 + 0; k++) begin
            drive(1, 0, 6'd1, '0, 1, 1, 1, AW'(k), 32'(k));
            cycle();
        end
        for (int k = 0; k < 20; k++) begin
            drive(1, 0, 6'd1, '0, 1, 1, 1, AW'(k), 32'(k));
            cycle();
        end
        chk("stall_cnt_sat", 32'(stall_cnt), 32'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
